// File: rtl/imm_encoder.sv
// Instruction-word encoder: packs a decoded field bundle into a 32-bit word and queues it in a small FIFO.
// Optional macro IMM_RANGE_CHECK_EN turns out-of-range immediates into NOP with an error flag.
`timescale 1ns/1ps
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_fmt_i,
    input  logic [6:0]       in_opcode_i,
    input  logic [4:0]       in_rd_i,
    input  logic [4:0]       in_rs1_i,
    input  logic [4:0]       in_rs2_i,
    input  logic [2:0]       in_funct3_i,
    input  logic [6:0]       in_funct7_i,
    input  logic [31:0]      in_imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_instr_o,
    output logic             out_err_o,
    output logic [CNT_W-1:0] enc_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

`ifdef IMM_RANGE_CHECK_EN
    function automatic logic imm_out_of_range(input logic [2:0] fmt, input logic [31:0] imm);
        logic signed [31:0] simm;
        logic               bad;
        simm = $signed(imm);
        case (fmt)
            FMT_I, FMT_S: bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
            FMT_J:        bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
            FMT_U:        bad = (imm[11:0] != 12'd0);
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    // Returns {err, word}; immediate bit placement mirrors the core's immediate decode.
    function automatic logic [32:0] encode_bundle(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] word;
        logic        err;
        err = 1'b0;
        case (fmt)
            FMT_R:   word = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   word = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   word = {imm[31:12], rd, op};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: begin
                word = NOP_WORD;
                err  = 1'b1;
            end
        endcase
`ifdef IMM_RANGE_CHECK_EN
        if (!err && imm_out_of_range(fmt, imm)) begin
            word = NOP_WORD;
            err  = 1'b1;
        end else begin
            word = word;
        end
`endif
        return {err, word};
    endfunction

    logic             ready_en_q, ready_en_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_word_q [DEPTH];
    logic             mem_err_q  [DEPTH];

    logic        push_s;
    logic        pop_s;
    logic        not_empty_s;
    logic [31:0] enc_word_s;
    logic        enc_err_s;

    // Ready, valid and handshake qualifiers; ready is gated until the first edge after reset.
    always_comb begin
        not_empty_s = (occ_q != {OCC_W{1'b0}});
        in_ready_o  = ready_en_q & (occ_q != FULL_OCC) & ~flush_i;
        out_valid_o = not_empty_s;
        push_s      = in_valid_i & in_ready_o;
        pop_s       = not_empty_s & out_ready_i & ~flush_i;
        {enc_err_s, enc_word_s} = encode_bundle(in_fmt_i, in_opcode_i, in_rd_i, in_rs1_i,
                                                in_rs2_i, in_funct3_i, in_funct7_i, in_imm_i);
    end

    // Head of queue; forced to zero while empty so reset presents a clean word.
    always_comb begin
        if (not_empty_s) begin
            out_instr_o = mem_word_q[rd_ptr_q];
            out_err_o   = mem_err_q[rd_ptr_q];
        end else begin
            out_instr_o = 32'h0000_0000;
            out_err_o   = 1'b0;
        end
        enc_count_o = cnt_q;
    end

    // Pointer, occupancy and counter next-state.
    always_comb begin
        ready_en_d = 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        cnt_d      = cnt_q;
        if (push_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            occ_d    = {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers and buffer storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ready_en_q <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            occ_q      <= {OCC_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_word_q[i] <= 32'h0000_0000;
                mem_err_q[i]  <= 1'b0;
            end
        end else begin
            ready_en_q <= ready_en_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            if (push_s) begin
                mem_word_q[wr_ptr_q] <= enc_word_s;
                mem_err_q[wr_ptr_q]  <= enc_err_s;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized self-checking bench for imm_encoder against a queue-based reference model.
`timescale 1ns/1ps
module tb_imm_encoder;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;

    imm_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_fmt_i(in_fmt),
        .in_opcode_i(in_opcode), .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_funct3_i(in_funct3), .in_funct7_i(in_funct7), .in_imm_i(in_imm),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
        .out_err_o(out_err), .enc_count_o(enc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } ent_t;

    ent_t q[$];
    int   cnt       = 0;
    bit   init_done = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference encoder: each field is shifted into place arithmetically from the format table.
    function automatic ent_t ref_encode(input logic [2:0] fmt, input int op, input int rd,
                                        input int rs1, input int rs2, input int f3,
                                        input int f7, input logic [31:0] imm);
        ent_t e;
        int   s;
        bit   bad;
        logic [31:0] w;
        s   = $signed(imm);
        bad = 1'b0;
        case (fmt)
            3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: begin
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                bad = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
                bad = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7) | op;
                bad = (s < -4096) || (s > 4094) || ((imm & 32'h1) != 32'h0);
            end
            3'd4: begin
                w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
                bad = ((imm & 32'hFFF) != 32'h0);
            end
            3'd5: begin
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000F_F000) | (rd << 7) | op;
                bad = (s < -1048576) || (s > 1048574) || ((imm & 32'h1) != 32'h0);
            end
            default: begin
                w = 32'h13;
                bad = 1'b1;
            end
        endcase
`ifndef IMM_RANGE_CHECK_EN
        if (fmt <= 3'd5) bad = 1'b0;
`endif
        e.word = bad ? 32'h0000_0013 : w;
        e.err  = bad;
        return e;
    endfunction

    function automatic bit model_ready();
        return init_done && (q.size() < DEPTH) && !flush;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
        if (q.size() != 0) begin
            check_eq("out_instr", out_instr, q[0].word);
            check_eq("out_err", {31'd0, out_err}, {31'd0, q[0].err});
        end
        check_eq("enc_count", 32'(enc_count), 32'(cnt));
    endtask

    // One clock cycle: pre-edge ready check, model update on the edge, post-edge output check.
    task automatic step();
        bit   acc, pop;
        ent_t e;
        #2;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
        acc = in_valid && model_ready();
        pop = (q.size() != 0) && out_ready && !flush;
        e   = ref_encode(in_fmt, int'(in_opcode), int'(in_rd), int'(in_rs1), int'(in_rs2),
                         int'(in_funct3), int'(in_funct7), in_imm);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (acc) q.push_back(e);
        end
        if (acc) cnt = (cnt + 1) % CNT_MOD;
        init_done = 1'b1;
        check_outputs();
    endtask

    task automatic drive_bundle(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic send_one(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic [31:0] exp_word, input logic exp_err);
        out_ready = 1'b1;
        drive_bundle(fmt, op, rd, rs1, rs2, 3'd0, 7'd0, imm);
        step();
        check_eq({tag, "_word"}, out_instr, exp_word);
        check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        in_valid = 1'b0;
        step();
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 8191)) - 4096);
            2:       return $urandom & 32'hFFFF_F000;
            default: return 32'($signed($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & 32'hFFFF_FFFE;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        #3;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        check_eq("rst_count", 32'(enc_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        send_one("i_basic", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        send_one("b_neg8", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE20_8CE3, 1'b0);
        send_one("j_800", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 32'h800, 32'h0010_00EF, 1'b0);
        send_one("u_lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
        send_one("i_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1);
`else
        send_one("i_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b0);
`endif
        send_one("fmt_111", 3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 32'd0, 32'h0000_0013, 1'b1);

        // Backpressure: three back-to-back bundles into a two-entry buffer.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_bundle(3'd0, 7'h33, 5'(k + 1), 5'(k + 2), 5'(k + 3), 3'(k), 7'h20, 32'd0);
            step();
        end
        check_eq("bp_count", 32'(enc_count), 32'((6 + 2) % CNT_MOD));
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Flush with two words buffered while a bundle is offered.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_bundle(3'd2, 7'h23, 5'd0, 5'(k), 5'(k + 7), 3'd2, 7'd0, 32'(k * 4));
            step();
        end
        flush = 1'b1; out_ready = 1'b1;
        step();
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_count", 32'(enc_count), 32'((9 + 2) % CNT_MOD));
        flush = 1'b0; in_valid = 1'b0;
        step();

        for (int n = 0; n < 400; n++) begin
            drive_bundle(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 24) == 0);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset with one word buffered.
        out_ready = 1'b0;
        drive_bundle(3'd1, 7'h13, 5'd9, 5'd8, 5'd0, 3'd0, 7'd0, 32'd77);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete(); cnt = 0; init_done = 1'b0;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_count", 32'(enc_count), 32'd0);
        check_eq("arst_out_instr", out_instr, 32'd0);
        check_eq("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("arst_hold_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
